// File: rtl/ht_head_table.sv
// Hash-table head-pointer lookup: a two-stage pipeline over a {ptr, valid} RAM, with write forwarding and clear/INIT sequencing.
// Define HT_HEAD_TABLE_STATS_EN to add the lookup and hit counters.
module ht_head_table #(
    parameter int KEY_WIDTH      = 32,
    parameter int VALUE_WIDTH    = 16,
    parameter int BUCKET_WIDTH   = 8,
    parameter int HEAD_PTR_WIDTH = 10,
    localparam int CMD_WIDTH     = KEY_WIDTH + VALUE_WIDTH,
    localparam int PDATA_WIDTH   = CMD_WIDTH + BUCKET_WIDTH + HEAD_PTR_WIDTH + 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [CMD_WIDTH-1:0]      cmd_i,
    input  logic [BUCKET_WIDTH-1:0]   bucket_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [PDATA_WIDTH-1:0]    pdata_o,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    input  logic                      wr_en_i,
    input  logic [BUCKET_WIDTH-1:0]   wr_bucket_i,
    input  logic [HEAD_PTR_WIDTH-1:0] wr_ptr_i,
    input  logic                      wr_ptr_val_i,
    input  logic                      clear_i,
    output logic                      busy_o
`ifdef HT_HEAD_TABLE_STATS_EN
    ,
    output logic [31:0]               lookup_cnt_o,
    output logic [31:0]               hit_cnt_o
`endif
);

    localparam int DEPTH = 1 << BUCKET_WIDTH;
    localparam int HW    = HEAD_PTR_WIDTH + 1;

    localparam logic [1:0] ST_INIT  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]              state;
    logic [BUCKET_WIDTH-1:0] init_addr;

    logic [HW-1:0]           ram [DEPTH];
    logic [HW-1:0]           ram_rdata;
    logic                    ram_we;
    logic [BUCKET_WIDTH-1:0] ram_waddr;
    logic [HW-1:0]           ram_wdata;

    logic                    pipe_en;
    logic                    accept;
    logic                    wr_act;
    logic [HW-1:0]           wr_data;

    logic                    s1_valid;
    logic [CMD_WIDTH-1:0]    s1_cmd;
    logic [BUCKET_WIDTH-1:0] s1_bucket;
    logic                    s1_ovr;
    logic [HW-1:0]           s1_ovr_data;
    logic [HW-1:0]           s1_eff;
    logic [HW-1:0]           s1_next_head;
    logic [BUCKET_WIDTH-1:0] out_bucket;
    logic                    pipe_empty;

    assign pipe_en    = !(out_valid_o && !out_ready_i);
    assign in_ready_o = (state == ST_RUN) && pipe_en;
    assign busy_o     = (state != ST_RUN);
    assign accept     = in_valid_i && in_ready_o;
    assign wr_act     = wr_en_i && (state != ST_INIT);
    assign wr_data    = {wr_ptr_i, wr_ptr_val_i};
    assign pipe_empty = !s1_valid && !out_valid_o;
    assign out_bucket = pdata_o[HW +: BUCKET_WIDTH];

    // INIT owns the write port; user writes are ignored until the table is zeroed.
    assign ram_we    = (state == ST_INIT) || wr_act;
    assign ram_waddr = (state == ST_INIT) ? init_addr : wr_bucket_i;
    assign ram_wdata = (state == ST_INIT) ? '0 : wr_data;

    always_ff @(posedge clk_i) begin
        if (ram_we)
            ram[ram_waddr] <= ram_wdata;
        if (pipe_en)
            ram_rdata <= ram[bucket_i];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= ST_INIT;
            init_addr <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    init_addr <= init_addr + 1'b1;
                    if (init_addr == '1)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    if (clear_i)
                        state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (pipe_empty) begin
                        state     <= ST_INIT;
                        init_addr <= '0;
                    end
                end
                default: state <= ST_INIT;
            endcase
        end
    end

    // A write that lands while a lookup waits in stage 1 is captured in an override,
    // since the RAM read data register holds the value sampled before the write.
    assign s1_eff       = s1_ovr ? s1_ovr_data : ram_rdata;
    assign s1_next_head = (wr_act && (wr_bucket_i == s1_bucket)) ? wr_data : s1_eff;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_valid <= 1'b0;
            s1_ovr   <= 1'b0;
        end else if (pipe_en) begin
            s1_valid <= accept;
            if (accept) begin
                s1_cmd      <= cmd_i;
                s1_bucket   <= bucket_i;
                s1_ovr      <= wr_act && (wr_bucket_i == bucket_i);
                s1_ovr_data <= wr_data;
            end
        end else if (wr_act && s1_valid && (wr_bucket_i == s1_bucket)) begin
            s1_ovr      <= 1'b1;
            s1_ovr_data <= wr_data;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_o <= 1'b0;
            pdata_o     <= '0;
        end else if (pipe_en) begin
            out_valid_o <= s1_valid;
            if (s1_valid)
                pdata_o <= {s1_cmd, s1_bucket, s1_next_head};
        end else if (wr_act && out_valid_o && (wr_bucket_i == out_bucket)) begin
            pdata_o[HW-1:0] <= wr_data;
        end
    end

`ifdef HT_HEAD_TABLE_STATS_EN
    logic out_fire;
    assign out_fire = out_valid_o && out_ready_i;

    // Counters restart whenever the table is re-initialised, so they describe the current table contents.
    always_ff @(posedge clk_i) begin
        if (rst_i || (state == ST_DRAIN && pipe_empty)) begin
            lookup_cnt_o <= '0;
            hit_cnt_o    <= '0;
        end else if (out_fire) begin
            lookup_cnt_o <= lookup_cnt_o + 32'd1;
            if (pdata_o[0])
                hit_cnt_o <= hit_cnt_o + 32'd1;
        end
    end
`else
    // No statistics hardware in this build.
`endif

endmodule

// File: tb/tb_ht_head_table.sv
// Self-checking bench for ht_head_table: vector table plus hand sequences, results scored through a queue.
// Stats checks are compiled only when HT_HEAD_TABLE_STATS_EN is defined.
module tb_ht_head_table;

    localparam int PW = 67;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [47:0]   cmd = '0;
    logic [7:0]    bucket = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [PW-1:0] pdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic          wr_en = 1'b0;
    logic [7:0]    wr_bucket = '0;
    logic [9:0]    wr_ptr = '0;
    logic          wr_val = 1'b0;
    logic          clear = 1'b0;
    logic          busy;
`ifdef HT_HEAD_TABLE_STATS_EN
    logic [31:0]   lookup_cnt;
    logic [31:0]   hit_cnt;
`endif

    logic [9:0]    exp_ptr = '0;
    logic          exp_val = 1'b0;
    logic [PW-1:0] sb_q[$];

    int n_checks = 0;
    int n_errors = 0;

    ht_head_table dut (
        .clk_i(clk), .rst_i(rst),
        .cmd_i(cmd), .bucket_i(bucket), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .pdata_o(pdata), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .wr_en_i(wr_en), .wr_bucket_i(wr_bucket), .wr_ptr_i(wr_ptr), .wr_ptr_val_i(wr_val),
        .clear_i(clear), .busy_o(busy)
`ifdef HT_HEAD_TABLE_STATS_EN
        , .lookup_cnt_o(lookup_cnt), .hit_cnt_o(hit_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [7:0]  wr_bucket;
        logic [9:0]  wr_ptr;
        logic        wr_val;
        logic [7:0]  lk_bucket;
        logic [47:0] cmd;
        logic [9:0]  exp_ptr;
        logic        exp_val;
    } vec_t;

    vec_t vecs[6];

    task automatic checkOutput(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic failTimeout(input string name);
        n_checks++;
        n_errors++;
        $display("[TB] FAIL %s: timed out waiting for DUT", name);
    endtask

    // Scoreboard: push the expected word at acceptance, pop and compare at each output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0)
                    checkOutput("unexpected_result", pdata, '0);
                else
                    checkOutput("result", pdata, sb_q.pop_front());
            end
            if (in_valid && in_ready)
                sb_q.push_back({cmd, bucket, exp_ptr, exp_val});
        end
    end

    task automatic applyStimulus(input logic [7:0] b, input logic [47:0] c,
                                 input logic [9:0] ep, input logic ev);
        int n = 0;
        bucket   = b;
        cmd      = c;
        exp_ptr  = ep;
        exp_val  = ev;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        if (!in_ready)
            failTimeout("accept");
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic doWrite(input logic [7:0] b, input logic [9:0] p, input logic v);
        wr_en     = 1'b1;
        wr_bucket = b;
        wr_ptr    = p;
        wr_val    = v;
        @(posedge clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
        if (n >= 200)
            failTimeout("idle");
    endtask

    task automatic doReset();
        rst      = 1'b1;
        in_valid = 1'b0;
        wr_en    = 1'b0;
        sb_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
    endtask

    // Starts at a negedge; counts consecutive busy cycles including the current one.
    task automatic countBusy(output int cnt);
        cnt = 0;
        while (busy && cnt < 2000) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int cnt;

        vecs[0] = '{1'b0, 8'd0,   10'd0,     1'b0, 8'd0,   48'hA000_0000_0001, 10'd0,     1'b0};
        vecs[1] = '{1'b0, 8'd0,   10'd0,     1'b0, 8'd127, 48'hA000_0000_0002, 10'd0,     1'b0};
        vecs[2] = '{1'b0, 8'd0,   10'd0,     1'b0, 8'd255, 48'hA000_0000_0003, 10'd0,     1'b0};
        vecs[3] = '{1'b1, 8'd200, 10'h3FF,   1'b1, 8'd200, 48'hA000_0000_0004, 10'h3FF,   1'b1};
        vecs[4] = '{1'b1, 8'd7,   10'h155,   1'b0, 8'd7,   48'hA000_0000_0005, 10'h155,   1'b0};
        vecs[5] = '{1'b0, 8'd0,   10'd0,     1'b0, 8'd6,   48'hA000_0000_0006, 10'd0,     1'b0};

        doReset();
        checkOutput("rst_busy", PW'(busy), PW'(1));
        checkOutput("rst_in_ready", PW'(in_ready), PW'(0));
        checkOutput("rst_out_valid", PW'(out_valid), PW'(0));
        checkOutput("rst_pdata", pdata, '0);
        countBusy(cnt);
        checkOutput("init_busy_cycles", PW'(cnt), PW'(256));
        checkOutput("init_ready", PW'(in_ready), PW'(1));
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            if (vecs[i].do_wr) begin
                waitIdle();
                doWrite(vecs[i].wr_bucket, vecs[i].wr_ptr, vecs[i].wr_val);
            end
            applyStimulus(vecs[i].lk_bucket, vecs[i].cmd, vecs[i].exp_ptr, vecs[i].exp_val);
        end
        waitIdle();

        // Write then lookup with exact two-cycle latency.
        doWrite(8'd5, 10'h3A, 1'b1);
        bucket = 8'd5; cmd = 48'hB000_0000_0005; exp_ptr = 10'h3A; exp_val = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        checkOutput("lat_accept", PW'(in_ready), PW'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        checkOutput("lat_cycle1", PW'(out_valid), PW'(0));
        @(negedge clk);
        checkOutput("lat_cycle2", PW'(out_valid), PW'(1));
        @(posedge clk);
        #1 waitIdle();

        // Same-cycle write plus a later write while the lookup is in stage 1.
        bucket = 8'd9; cmd = 48'hC000_0000_0009; exp_ptr = 10'h22; exp_val = 1'b1; in_valid = 1'b1;
        wr_en = 1'b1; wr_bucket = 8'd9; wr_ptr = 10'h11; wr_val = 1'b1;
        @(negedge clk);
        checkOutput("fwd_accept", PW'(in_ready), PW'(1));
        @(posedge clk);
        #1 in_valid = 1'b0;
        wr_ptr = 10'h22;
        @(posedge clk);
        #1 wr_en = 1'b0;
        waitIdle();

        // Backpressure for 10 cycles with three lookups queued.
        out_ready = 1'b0;
        fork
            begin
                applyStimulus(8'd5,   48'hD000_0000_0001, 10'h3A,  1'b1);
                applyStimulus(8'd9,   48'hD000_0000_0002, 10'h22,  1'b1);
                applyStimulus(8'd200, 48'hD000_0000_0003, 10'h3FF, 1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                checkOutput("stall_pdata_early", pdata, {48'hD000_0000_0001, 8'd5, 10'h3A, 1'b1});
                repeat (7) @(negedge clk);
                checkOutput("stall_in_ready", PW'(in_ready), PW'(0));
                checkOutput("stall_out_valid", PW'(out_valid), PW'(1));
                checkOutput("stall_pdata_late", pdata, {48'hD000_0000_0001, 8'd5, 10'h3A, 1'b1});
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        waitIdle();

        // Clear with two lookups in flight.
        applyStimulus(8'd5, 48'hE000_0000_0001, 10'h3A, 1'b1);
        applyStimulus(8'd9, 48'hE000_0000_0002, 10'h22, 1'b1);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        checkOutput("drain_busy", PW'(busy), PW'(1));
        checkOutput("drain_in_ready", PW'(in_ready), PW'(0));
        countBusy(cnt);
        checkOutput("clear_busy_len", PW'(cnt >= 256 && cnt <= 260), PW'(1));
        checkOutput("clear_delivered", PW'(sb_q.size()), PW'(0));
        @(posedge clk);
        #1;
        applyStimulus(8'd5,   48'hE000_0000_0003, 10'd0, 1'b0);
        applyStimulus(8'd200, 48'hE000_0000_0004, 10'd0, 1'b0);
        waitIdle();

        // Reset while stalled discards the in-flight lookups.
        out_ready = 1'b0;
        applyStimulus(8'd9, 48'hF000_0000_0001, 10'h22, 1'b1);
        applyStimulus(8'd7, 48'hF000_0000_0002, 10'h155, 1'b0);
        doReset();
        checkOutput("rst2_out_valid", PW'(out_valid), PW'(0));
        checkOutput("rst2_busy", PW'(busy), PW'(1));
        checkOutput("rst2_pdata", pdata, '0);
        countBusy(cnt);
        checkOutput("rst2_busy_cycles", PW'(cnt), PW'(256));
        @(posedge clk);
        #1;
        applyStimulus(8'd9, 48'hF000_0000_0003, 10'd0, 1'b0);
        waitIdle();

`ifdef HT_HEAD_TABLE_STATS_EN
        doReset();
        countBusy(cnt);
        @(posedge clk);
        #1 doWrite(8'd3, 10'h001, 1'b1);
        applyStimulus(8'd3, 48'h5000_0000_0001, 10'h001, 1'b1);
        applyStimulus(8'd0, 48'h5000_0000_0002, 10'd0, 1'b0);
        applyStimulus(8'd1, 48'h5000_0000_0003, 10'd0, 1'b0);
        applyStimulus(8'd2, 48'h5000_0000_0004, 10'd0, 1'b0);
        waitIdle();
        checkOutput("stats_lookups", PW'(lookup_cnt), PW'(4));
        checkOutput("stats_hits", PW'(hit_cnt), PW'(1));
        doReset();
        checkOutput("stats_lookups_rst", PW'(lookup_cnt), PW'(0));
        checkOutput("stats_hits_rst", PW'(hit_cnt), PW'(0));
`endif

        repeat (5) @(posedge clk);
        checkOutput("sb_empty", PW'(sb_q.size()), PW'(0));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
